// File: rtl/shift_rotate_unit.sv
// Iterative shift/rotate engine: SHR, SHRA, SHL, ROR, ROL on WIDTH-bit operands,
// up to STEP bit positions per clock, with a start/busy/done handshake.
module shift_rotate_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned STEP = 1,
    localparam int unsigned SHAMT_W = $clog2(WIDTH)
) (
    input  logic               i_clk,
    input  logic               i_clear,
    input  logic               i_start,
    input  logic [2:0]         i_op,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [SHAMT_W-1:0] i_shamt,
    output logic [WIDTH-1:0]   o_result,
    output logic               o_cout,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_bad_op
);

    localparam int unsigned KW = SHAMT_W + 1;
    localparam logic [2:0] OP_SHR  = 3'd0;
    localparam logic [2:0] OP_SHRA = 3'd1;
    localparam logic [2:0] OP_SHL  = 3'd2;
    localparam logic [2:0] OP_ROR  = 3'd3;
    localparam logic [2:0] OP_ROL  = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_result;
    logic [WIDTH-1:0]   w_result_nxt;
    logic [WIDTH-1:0]   w_step_res;
    logic [2:0]         r_op;
    logic [2:0]         w_op_nxt;
    logic [SHAMT_W-1:0] r_remain;
    logic [SHAMT_W-1:0] w_remain_nxt;
    logic [SHAMT_W-1:0] w_k;
    logic [SHAMT_W-1:0] w_k_m1;
    logic [SHAMT_W-1:0] w_k_neg;
    logic               r_cout;
    logic               w_cout_nxt;
    logic               w_step_cout;
    logic               r_busy;
    logic               w_busy_nxt;
    logic               r_done;
    logic               w_done_nxt;
    logic               r_bad_op;
    logic               w_bad_nxt;
    logic               w_op_legal;
    logic               w_accept;
    logic               w_last;

    assign w_op_legal = (i_op <= OP_ROL);
    assign w_accept   = i_start && (r_state != S_RUN);

    // Positions handled this cycle: k = min(STEP, remaining)
    always_comb begin
        w_k = r_remain;
        if ({1'b0, r_remain} > KW'(STEP)) begin
            w_k = SHAMT_W'(STEP);
        end
    end

    // WIDTH is a power of two, so -k modulo WIDTH equals WIDTH-k for k >= 1
    assign w_k_m1  = w_k - SHAMT_W'(1);
    assign w_k_neg = SHAMT_W'(0) - w_k;
    assign w_last  = (r_remain == w_k);

    // One k-position step of the latched operation
    always_comb begin
        w_step_res  = r_result;
        w_step_cout = 1'b0;
        case (r_op)
            OP_SHR: begin
                w_step_res  = r_result >> w_k;
                w_step_cout = r_result[w_k_m1];
            end
            OP_SHRA: begin
                w_step_res  = $unsigned($signed(r_result) >>> w_k);
                w_step_cout = r_result[w_k_m1];
            end
            OP_SHL: begin
                w_step_res  = r_result << w_k;
                w_step_cout = r_result[w_k_neg];
            end
            OP_ROR: begin
                w_step_res  = (r_result >> w_k) | (r_result << w_k_neg);
                w_step_cout = r_result[w_k_m1];
            end
            OP_ROL: begin
                w_step_res  = (r_result << w_k) | (r_result >> w_k_neg);
                w_step_cout = r_result[w_k_neg];
            end
            default: begin
                w_step_res  = r_result;
                w_step_cout = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_clear) begin
        if (!i_clear) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (i_start) begin
                    w_state_nxt = ((i_shamt != '0) && w_op_legal) ? S_RUN : S_DONE;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Next values for the registered datapath and status outputs
    always_comb begin
        w_result_nxt = r_result;
        w_cout_nxt   = r_cout;
        w_remain_nxt = r_remain;
        w_op_nxt     = r_op;
        w_bad_nxt    = r_bad_op;
        w_busy_nxt   = (w_state_nxt == S_RUN);
        w_done_nxt   = (w_state_nxt == S_DONE);
        if (w_accept) begin
            w_result_nxt = i_a;
            w_cout_nxt   = 1'b0;
            w_remain_nxt = i_shamt;
            w_op_nxt     = i_op;
            w_bad_nxt    = !w_op_legal;
        end else if (r_state == S_RUN) begin
            w_result_nxt = w_step_res;
            w_cout_nxt   = w_step_cout;
            w_remain_nxt = r_remain - w_k;
        end
    end

    always_ff @(posedge i_clk or negedge i_clear) begin
        if (!i_clear) begin
            r_result <= '0;
            r_cout   <= 1'b0;
            r_remain <= '0;
            r_op     <= 3'd0;
            r_bad_op <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_result <= w_result_nxt;
            r_cout   <= w_cout_nxt;
            r_remain <= w_remain_nxt;
            r_op     <= w_op_nxt;
            r_bad_op <= w_bad_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
        end
    end

    assign o_result = r_result;
    assign o_cout   = r_cout;
    assign o_busy   = r_busy;
    assign o_done   = r_done;
    assign o_bad_op = r_bad_op;

endmodule

// File: tb/tb_shift_rotate_unit.sv
// Bench for shift_rotate_unit: three instances (32/1, 32/4, 8/2) driven by
// scenario tasks; expected results are queued at launch and popped on done.
module tb_shift_rotate_unit;

    typedef struct {
        logic [31:0] res;
        logic        cout;
        logic        bad;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        clear;
    logic        s_start [3];
    logic [2:0]  s_op    [3];
    logic [31:0] s_a     [3];
    logic [4:0]  s_shamt [3];
    logic [31:0] w_res   [3];
    logic        w_cout  [3];
    logic        w_busy  [3];
    logic        w_done  [3];
    logic        w_bad   [3];
    logic [31:0] res_a;
    logic [31:0] res_b;
    logic [7:0]  res_c;

    int W     [3] = '{32, 32, 8};
    int STEPS [3] = '{1, 4, 2};

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    shift_rotate_unit #(.WIDTH(32), .STEP(1)) u_a (
        .i_clk(clk), .i_clear(clear), .i_start(s_start[0]), .i_op(s_op[0]),
        .i_a(s_a[0]), .i_shamt(s_shamt[0]), .o_result(res_a), .o_cout(w_cout[0]),
        .o_busy(w_busy[0]), .o_done(w_done[0]), .o_bad_op(w_bad[0])
    );

    shift_rotate_unit #(.WIDTH(32), .STEP(4)) u_b (
        .i_clk(clk), .i_clear(clear), .i_start(s_start[1]), .i_op(s_op[1]),
        .i_a(s_a[1]), .i_shamt(s_shamt[1]), .o_result(res_b), .o_cout(w_cout[1]),
        .o_busy(w_busy[1]), .o_done(w_done[1]), .o_bad_op(w_bad[1])
    );

    shift_rotate_unit #(.WIDTH(8), .STEP(2)) u_c (
        .i_clk(clk), .i_clear(clear), .i_start(s_start[2]), .i_op(s_op[2]),
        .i_a(s_a[2][7:0]), .i_shamt(s_shamt[2][2:0]), .o_result(res_c), .o_cout(w_cout[2]),
        .o_busy(w_busy[2]), .o_done(w_done[2]), .o_bad_op(w_bad[2])
    );

    assign w_res[0] = res_a;
    assign w_res[1] = res_b;
    assign w_res[2] = {24'd0, res_c};

    function automatic exp_t mk(logic [31:0] res, logic cout, logic bad, int lat);
        exp_t e;
        e.res  = res;
        e.cout = cout;
        e.bad  = bad;
        e.lat  = lat;
        return e;
    endfunction

    function automatic int lat_of(int u, logic [2:0] op, int n);
        if (op > 3'd4 || n == 0) return 0;
        return (n + STEPS[u] - 1) / STEPS[u];
    endfunction

    // Bit-serial reference: one position at a time on a w-bit value
    function automatic exp_t model(int u, logic [2:0] op, logic [31:0] a, int n);
        int          w = W[u];
        logic [31:0] mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        logic [31:0] r = a & mask;
        logic        c = 1'b0;
        logic        msb;
        if (op > 3'd4) return mk(r, 1'b0, 1'b1, 0);
        for (int i = 0; i < n; i++) begin
            msb = r[w-1];
            case (op)
                3'd0: begin c = r[0]; r = r >> 1; end
                3'd1: begin c = r[0]; r = (r >> 1) | ({31'd0, msb} << (w - 1)); end
                3'd2: begin c = msb;  r = (r << 1) & mask; end
                3'd3: begin c = r[0]; r = (r >> 1) | ({31'd0, c} << (w - 1)); end
                default: begin c = msb; r = ((r << 1) & mask) | {31'd0, c}; end
            endcase
        end
        return mk(r, c, 1'b0, lat_of(u, op, n));
    endfunction

    // Drive a start for one edge from the current (negedge) time and queue its expectation
    task automatic launch(input int u, input logic [2:0] op, input logic [31:0] a,
                          input int n, input exp_t e);
        s_start[u] = 1'b1;
        s_op[u]    = op;
        s_a[u]     = a;
        s_shamt[u] = 5'(n);
        sb.push_back(e);
    endtask

    // Wait for done (bounded); inj > 0 pulses a start at edge inj while running
    task automatic complete(input int u, input string tag, input int inj, output exp_t e);
        int edge_n = 0;
        int busy_n = 0;
        bit seen   = 1'b0;
        e = mk(32'd0, 1'b0, 1'b0, 0);
        while (!seen && edge_n < 100) begin
            @(negedge clk);
            if (edge_n == 0) s_start[u] = 1'b0;
            if (inj > 0 && edge_n == inj - 1) begin
                s_start[u] = 1'b1; s_op[u] = 3'd0; s_a[u] = 32'd1; s_shamt[u] = 5'd1;
            end
            if (inj > 0 && edge_n == inj) s_start[u] = 1'b0;
            n_checks++;
            if (w_busy[u] && w_done[u]) begin
                n_errors++;
                $display("FAIL %s busy_and_done at edge %0d", tag, edge_n);
            end
            if (w_busy[u]) busy_n++;
            if (w_done[u]) begin
                seen = 1'b1;
                e = sb.pop_front();
                n_checks++;
                if (w_res[u] !== e.res) begin
                    n_errors++;
                    $display("FAIL %s result got %h exp %h", tag, w_res[u], e.res);
                end
                n_checks++;
                if (w_cout[u] !== e.cout) begin
                    n_errors++;
                    $display("FAIL %s cout got %b exp %b", tag, w_cout[u], e.cout);
                end
                n_checks++;
                if (w_bad[u] !== e.bad) begin
                    n_errors++;
                    $display("FAIL %s bad_op got %b exp %b", tag, w_bad[u], e.bad);
                end
                n_checks++;
                if (edge_n != e.lat) begin
                    n_errors++;
                    $display("FAIL %s done_edge got %0d exp %0d", tag, edge_n, e.lat);
                end
                n_checks++;
                if (busy_n != e.lat) begin
                    n_errors++;
                    $display("FAIL %s busy_cycles got %0d exp %0d", tag, busy_n, e.lat);
                end
            end else begin
                edge_n++;
            end
        end
        if (!seen) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s timeout waiting for done", tag);
            if (sb.size() > 0) void'(sb.pop_front());
        end
    endtask

    // One cycle after done: pulse gone, outputs held
    task automatic check_idle(input int u, input string tag, input exp_t e);
        @(negedge clk);
        n_checks++;
        if (w_done[u] !== 1'b0 || w_busy[u] !== 1'b0) begin
            n_errors++;
            $display("FAIL %s post_done busy/done got %b/%b exp 0/0", tag, w_busy[u], w_done[u]);
        end
        n_checks++;
        if (w_res[u] !== e.res || w_cout[u] !== e.cout || w_bad[u] !== e.bad) begin
            n_errors++;
            $display("FAIL %s hold got %h/%b/%b exp %h/%b/%b", tag,
                     w_res[u], w_cout[u], w_bad[u], e.res, e.cout, e.bad);
        end
    endtask

    task automatic check_zero(input int u, input string tag);
        n_checks++;
        if (w_res[u] !== 32'd0 || w_cout[u] !== 1'b0 || w_busy[u] !== 1'b0 ||
            w_done[u] !== 1'b0 || w_bad[u] !== 1'b0) begin
            n_errors++;
            $display("FAIL %s reset got res %h cout %b busy %b done %b bad %b exp all 0", tag,
                     w_res[u], w_cout[u], w_busy[u], w_done[u], w_bad[u]);
        end
    endtask

    task automatic test_reset();
        clear = 1'b0;
        for (int u = 0; u < 3; u++) begin
            s_start[u] = 1'b0; s_op[u] = 3'd0; s_a[u] = 32'd0; s_shamt[u] = 5'd0;
        end
        repeat (2) @(negedge clk);
        for (int u = 0; u < 3; u++) check_zero(u, "reset");
        clear = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_rol_step1();
        exp_t e;
        launch(0, 3'd4, 32'hFFFF_FFF4, 5, mk(32'hFFFF_FE9F, 1'b1, 1'b0, 5));
        complete(0, "rol_step1", 0, e);
        check_idle(0, "rol_step1", e);
    endtask

    task automatic test_zero_illegal();
        exp_t e;
        launch(0, 3'd2, 32'h0000_000F, 0, mk(32'h0000_000F, 1'b0, 1'b0, 0));
        complete(0, "shl_n0", 0, e);
        check_idle(0, "shl_n0", e);
        launch(0, 3'd5, 32'h1234_5678, 3, mk(32'h1234_5678, 1'b0, 1'b1, 0));
        complete(0, "illegal", 0, e);
        check_idle(0, "illegal", e);
    endtask

    task automatic test_ignored_start();
        exp_t e;
        launch(0, 3'd0, 32'hF000_0000, 8, mk(32'h00F0_0000, 1'b0, 1'b0, 8));
        complete(0, "start_in_run", 3, e);
        check_idle(0, "start_in_run", e);
    endtask

    task automatic test_back_to_back();
        exp_t e;
        launch(1, 3'd1, 32'h8000_0000, 31, mk(32'hFFFF_FFFF, 1'b0, 1'b0, 8));
        complete(1, "shra_step4", 0, e);
        launch(1, 3'd3, 32'h0000_0001, 1, mk(32'h8000_0000, 1'b1, 1'b0, 1));
        complete(1, "ror_b2b", 0, e);
        check_idle(1, "ror_b2b", e);
    endtask

    task automatic test_width8();
        exp_t e;
        launch(2, 3'd3, 32'h0000_0081, 7, mk(32'h0000_0003, 1'b0, 1'b0, 4));
        complete(2, "ror_w8", 0, e);
        check_idle(2, "ror_w8", e);
    endtask

    task automatic test_reset_midrun();
        exp_t e;
        launch(0, 3'd4, 32'h1234_5678, 20, mk(32'd0, 1'b0, 1'b0, 20));
        @(negedge clk);
        s_start[0] = 1'b0;
        repeat (6) @(negedge clk);
        n_checks++;
        if (w_busy[0] !== 1'b1) begin
            n_errors++;
            $display("FAIL midrun busy got %b exp 1", w_busy[0]);
        end
        clear = 1'b0;
        #1;
        check_zero(0, "midrun_clear");
        void'(sb.pop_front());
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        launch(0, 3'd2, 32'h0000_0001, 3, mk(32'h0000_0008, 1'b0, 1'b0, 3));
        complete(0, "shl_after_clear", 0, e);
        check_idle(0, "shl_after_clear", e);
    endtask

    task automatic test_random();
        exp_t        e;
        logic [2:0]  op;
        logic [31:0] a;
        int          n;
        for (int u = 0; u < 3; u++) begin
            for (int k = 0; k < 8; k++) begin
                op = 3'($urandom_range(5));
                a  = $urandom;
                n  = $urandom_range(W[u] - 1);
                launch(u, op, a, n, model(u, op, a, n));
                complete(u, "random", 0, e);
                if (k % 2 == 1) check_idle(u, "random", e);
            end
            check_idle(u, "random_end", e);
        end
    endtask

    initial begin
        test_reset();
        test_rol_step1();
        test_zero_illegal();
        test_ignored_start();
        test_back_to_back();
        test_width8();
        test_reset_midrun();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
